// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready handshakes.
// A channel is chosen round-robin or by a fixed select, and its word is loaded into a one-entry output stage.
module mux_n_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic           sel_mode,
  input  logic [CW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  input  logic           out_ready
);

  logic [N-1:0][W-1:0] data_arr;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       g;
  logic                found;
  logic                load_ok;
  logic                load;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*W +: W];
    end
  endgenerate

  assign load_ok = !out_valid || out_ready;

  // The round-robin scan starts at ptr and wraps at N-1, so non-power-of-two N never yields an index >= N.
  always_comb begin
    int idx;
    found = 1'b0;
    g     = '0;
    idx   = 0;
    if (sel_mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        found = 1'b1;
        g     = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          g     = CW'(idx);
        end
      end
    end
  end

  assign load = load_ok && found && !rst;

  always_comb begin
    in_ready = '0;
    if (load) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[g];
      out_ch    <= g;
      if (!sel_mode) ptr <= (int'(g) == N-1) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed self-checking bench for mux_n_rr with N=4 and W=8.
module tb_mux_n_rr;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        sel_mode;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mux_n_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sel_mode(sel_mode), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; sel_mode = 1'b0; sel = 2'd0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_in_ready cyc%0d: got %b want 0000", c, in_ready);
      end
      tick();
    end
    rst = 1'b0; in_valid = 4'b0000;
    settle();
    n_checks++;
    if ({out_valid, out_data, out_ch} !== {1'b0, 8'h00, 2'd0}) begin
      n_fail++; $display("FAIL reset_out: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ch;
    logic [3:0] exp_rdy;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch = 2'(i % 4);
      exp_rdy = 4'b0001 << ch;
      settle();
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, in_ready, exp_rdy);
      end
      tick();
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, ch, 8'hA0 + 8'(ch)}) begin
        n_fail++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                           i, out_valid, out_ch, out_data, ch, 8'hA0 + 8'(ch));
      end
    end
    // ptr now 1; drain with no requests
    in_valid = 4'b0000;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_skip_wrap();
    logic [1:0] seq [3];
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd0;
    // load ch2 from ptr=1 so ptr becomes 3
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (in_ready !== (4'b0001 << seq[i])) begin
        n_fail++; $display("FAIL skip_grant[%0d]: got %b want %b", i, in_ready, 4'b0001 << seq[i]);
      end
      tick();
      n_checks++;
      if ({out_valid, out_ch} !== {1'b1, seq[i]}) begin
        n_fail++; $display("FAIL skip_out[%0d]: got v=%b ch=%0d want v=1 ch=%0d", i, out_valid, out_ch, seq[i]);
      end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    // ptr=1, output empty
    in_valid = 4'b1111; out_ready = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_first_grant: got %b want 0010", in_ready);
    end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'hA1}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=1 d=A1", c, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_grant: got %b want 0100", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA2}) begin
      n_fail++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%h want v=1 ch=2 d=A2", out_valid, out_ch, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fixed();
    // ptr=3 going in
    sel_mode = 1'b1; sel = 2'd2; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (in_ready !== 4'b0100) begin
        n_fail++; $display("FAIL fixed_grant[%0d]: got %b want 0100", i, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA2}) begin
        n_fail++; $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=2 d=A2", i, out_valid, out_ch, out_data);
      end
    end
    in_valid = 4'b1011;
    settle();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL fixed_nogrant: got %b want 0000", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ch, out_data} !== {1'b0, 2'd2, 8'hA2}) begin
      n_fail++; $display("FAIL fixed_drain: got v=%b ch=%0d d=%h want v=0 ch=2 d=A2", out_valid, out_ch, out_data);
    end
    // back to round-robin: ptr must still be 3
    sel_mode = 1'b0; in_valid = 4'b1111;
    settle();
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++; $display("FAIL fixed_ptr_kept: got %b want 1000", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'hA3}) begin
      n_fail++; $display("FAIL mode_switch_out: got v=%b ch=%0d d=%h want v=1 ch=3 d=A3", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_reset_mid();
    // one more load so ptr=1, then stall and reset
    tick();
    out_ready = 1'b0; rst = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_in_ready: got %b want 0000", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid);
    end
    rst = 1'b0; out_ready = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_grant: got %b want 0001", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
      n_fail++; $display("FAIL rstmid_out: got v=%b ch=%0d d=%h want v=1 ch=0 d=A0", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; sel_mode = 1'b0; sel = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_fixed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
